// File: rtl/input_debounce_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : input_debounce_pio_pkg
// Purpose  : Register map constants and counter sizing for input_debounce_pio
// Revision : 1.0 - initial release
// ============================================================================
package input_debounce_pio_pkg;

  localparam logic [1:0] ADDR_DATA         = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK     = 2'd1;
  localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd2;
  localparam logic [1:0] ADDR_EDGE_SEL     = 2'd3;

  // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/input_debounce_pio_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Purpose  : One-bit synchroniser plus stable-level debounce counter
// Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
  import input_debounce_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   SYNC_STAGES     = 2,
  parameter logic RESET_BIT       = 1'b0
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic pin,
  output logic stable
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sync   <= {SYNC_STAGES{RESET_BIT}};
      r_cnt    <= '0;
      r_stable <= RESET_BIT;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pin};
      if (r_sync[SYNC_STAGES-1] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/input_debounce_pio.sv
`default_nettype none
// ============================================================================
// Module   : input_debounce_pio
// Purpose  : Debounced PIO input group with edge capture and maskable IRQ
// Revision : 1.0 - initial release
// ============================================================================
module input_debounce_pio
  import input_debounce_pio_pkg::*;
#(
  parameter int               WIDTH           = 10,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               SYNC_STAGES     = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [WIDTH-1:0] pins_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_mask_nxt;
  logic [WIDTH-1:0] w_sel_nxt;
  logic [WIDTH-1:0] w_cap_nxt;
  logic [31:0]      w_rd_mux;
  logic             w_unused;

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] r_edge_sel;
  logic [31:0]      r_readdata;
  logic             r_irq;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .RESET_BIT       (RESET_VALUE[i])
    ) u_ch (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .pin         (pins_in[i]),
      .stable      (w_stable[i])
    );
  end

  assign w_wdata  = avs_writedata[WIDTH-1:0];
  assign w_unused = ^avs_writedata;

  always_comb begin
    w_event    = (w_stable & ~r_prev & ~r_edge_sel) | (~w_stable & r_prev & r_edge_sel);
    w_mask_nxt = r_irq_mask;
    w_sel_nxt  = r_edge_sel;
    w_cap_nxt  = r_edge_cap;
    if (avs_write) begin
      case (avs_address)
        ADDR_IRQ_MASK:     w_mask_nxt = w_wdata;
        ADDR_EDGE_CAPTURE: w_cap_nxt  = r_edge_cap & ~w_wdata;
        ADDR_EDGE_SEL:     w_sel_nxt  = w_wdata;
        default:           ;
      endcase
    end
    // A new event overrides a same-cycle clear.
    w_cap_nxt = w_cap_nxt | w_event;

    w_rd_mux = '0;
    case (avs_address)
      ADDR_DATA:         w_rd_mux[WIDTH-1:0] = w_stable;
      ADDR_IRQ_MASK:     w_rd_mux[WIDTH-1:0] = r_irq_mask;
      ADDR_EDGE_CAPTURE: w_rd_mux[WIDTH-1:0] = r_edge_cap;
      default:           w_rd_mux[WIDTH-1:0] = r_edge_sel;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_prev     <= RESET_VALUE;
      r_irq_mask <= '0;
      r_edge_cap <= '0;
      r_edge_sel <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_prev     <= w_stable;
      r_irq_mask <= w_mask_nxt;
      r_edge_cap <= w_cap_nxt;
      r_edge_sel <= w_sel_nxt;
      r_irq      <= |(w_cap_nxt & w_mask_nxt);
      if (avs_read) begin
        r_readdata <= w_rd_mux;
      end
    end
  end

  assign avs_readdata = r_readdata;
  assign irq          = r_irq;

endmodule
`default_nettype wire
